// File: rtl/apb_cmd_master.sv
// ============================================================================
// Module      : apb_cmd_master
// Description : Single-outstanding APB requester that runs one valid/ready
//               command through SETUP/ACCESS and returns a held response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strobe,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic                    sel,
    output logic                    enable,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic                    write,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] strobe,
    input  logic                    ready,
    input  logic                    slverr,
    input  logic [DATA_WIDTH-1:0]   rdata
);

    localparam int c_strb_w = DATA_WIDTH / 8;
    localparam int c_cnt_w  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_resp   = 2'd3;

    logic [1:0]            r_state;
    logic                  r_sel;
    logic                  r_enable;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_strb_w-1:0]   r_strobe;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_slverr;
    logic                  r_rsp_timeout;
    logic [c_cnt_w-1:0]    r_cnt;

    logic w_cmd_ready;
    logic w_accept;
    logic w_timeout_hit;

    // A response being consumed frees the slot in the same cycle, so a new
    // command can be taken without passing through IDLE.
    assign w_cmd_ready = (r_state == c_st_idle) ||
                         ((r_state == c_st_resp) && rsp_ready);
    assign w_accept    = cmd_valid && w_cmd_ready;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout_hit = (r_cnt == c_cnt_w'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_sel         <= 1'b0;
            r_enable      <= 1'b0;
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_wdata       <= '0;
            r_strobe      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                c_st_idle, c_st_resp: begin
                    if ((r_state == c_st_resp) && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                    if (w_accept) begin
                        r_addr   <= cmd_addr;
                        r_write  <= cmd_write;
                        r_wdata  <= cmd_wdata;
                        r_strobe <= cmd_write ? cmd_strobe : '0;
                        r_sel    <= 1'b1;
                        r_enable <= 1'b0;
                        r_state  <= c_st_setup;
                    end
                end
                c_st_setup: begin
                    r_enable <= 1'b1;
                    r_cnt    <= '0;
                    r_state  <= c_st_access;
                end
                c_st_access: begin
                    if (ready) begin
                        r_rsp_slverr  <= slverr;
                        r_rsp_rdata   <= (!r_write && !slverr) ? rdata : '0;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_sel         <= 1'b0;
                        r_enable      <= 1'b0;
                        r_state       <= c_st_resp;
                    end else if (w_timeout_hit) begin
                        r_rsp_slverr  <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_sel         <= 1'b0;
                        r_enable      <= 1'b0;
                        r_state       <= c_st_resp;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_slverr  = r_rsp_slverr;
    assign rsp_timeout = r_rsp_timeout;
    assign sel         = r_sel;
    assign enable      = r_enable;
    assign addr        = r_addr;
    assign write       = r_write;
    assign wdata       = r_wdata;
    assign strobe      = r_strobe;

endmodule

`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
// ============================================================================
// Module      : tb_apb_cmd_master
// Description : Directed, table-driven bench for apb_cmd_master with a
//               wait-state programmable completer model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_strobe;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr, rsp_timeout;
    logic          sel, enable, write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    strobe;
    logic          ready = 1'b0;
    logic          slverr;
    logic [DW-1:0] rdata;

    int            n_checks = 0;
    int            n_errors = 0;

    int            wait_cfg = 0;
    int            wcnt     = 0;
    logic          cpl_slverr = 1'b0;
    logic [DW-1:0] cpl_rdata  = '0;

    apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strobe(cmd_strobe),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .sel(sel), .enable(enable), .addr(addr), .write(write),
        .wdata(wdata), .strobe(strobe),
        .ready(ready), .slverr(slverr), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Completer: raises ready after wait_cfg ACCESS cycles have elapsed.
    always @(negedge clk) begin
        if (sel && enable) begin
            ready = (wcnt >= wait_cfg);
            wcnt  = wcnt + 1;
        end else begin
            ready = 1'b0;
            wcnt  = 0;
        end
    end
    assign slverr = cpl_slverr;
    assign rdata  = cpl_rdata;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  strb;
        int          wait_n;
        logic        serr;
        logic [31:0] rd;
        logic [31:0] exp_rdata;
        logic        exp_serr;
        logic        exp_to;
        int          exp_lat;
        int          exp_en;
        logic [3:0]  exp_strb;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_valid_after_ack", rsp_valid, 0);
    endtask

    // Latency counts the accept edge as edge 1.
    task automatic run_vec(input vec_t v, input bit ack);
        int edges, en_cyc, sel_cyc, bus_err;
        bit done;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_write  = v.wr;
        cmd_addr   = v.a;
        cmd_wdata  = v.wd;
        cmd_strobe = v.strb;
        wait_cfg   = v.wait_n;
        cpl_slverr = v.serr;
        cpl_rdata  = v.rd;
        rsp_ready  = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_write  = ~v.wr;
        cmd_addr   = '1;
        cmd_wdata  = ~v.wd;
        cmd_strobe = ~v.strb;
        edges = 1; en_cyc = 0; sel_cyc = 0; bus_err = 0; done = 0;
        while (!done && edges < 40) begin
            @(negedge clk);
            if (rsp_valid) begin
                done = 1;
            end else begin
                if (enable) en_cyc++;
                if (sel) begin
                    sel_cyc++;
                    if (addr !== v.a || write !== v.wr || strobe !== v.exp_strb) bus_err++;
                    if (v.wr && wdata !== v.wd) bus_err++;
                end
                @(posedge clk);
                edges++;
            end
        end
        check("rsp_seen", done, 1);
        check("latency", edges, v.exp_lat);
        check("enable_cycles", en_cyc, v.exp_en);
        check("sel_cycles", sel_cyc, v.exp_en + 1);
        check("bus_stable", bus_err, 0);
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("rsp_slverr", rsp_slverr, v.exp_serr);
        check("rsp_timeout", rsp_timeout, v.exp_to);
        check("bus_idle_in_resp", {sel, enable}, 0);
        if (ack) ack_rsp();
    endtask

    vec_t vecs[6];

    initial begin
        vec_t b;
        logic [DW-1:0] s_rdata;
        logic s_serr, s_to;
        bit done;
        int stable_err, spurious;

        vecs[0] = '{1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 0,   1'b0, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 3, 1, 4'hF};
        vecs[1] = '{1'b0, 32'h20, 32'h5555_0000, 4'hF, 2,   1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 5, 3, 4'h0};
        vecs[2] = '{1'b0, 32'h24, 32'h0,         4'hF, 0,   1'b1, 32'h0000_1234, 32'h0,         1'b1, 1'b0, 3, 1, 4'h0};
        vecs[3] = '{1'b0, 32'h28, 32'h0,         4'hF, 100, 1'b0, 32'h1111_2222, 32'h0,         1'b1, 1'b1, 6, 4, 4'h0};
        vecs[4] = '{1'b1, 32'h30, 32'h0102_0304, 4'h5, 1,   1'b1, 32'h7777_7777, 32'h0,         1'b1, 1'b0, 4, 2, 4'h5};
        vecs[5] = '{1'b0, 32'h34, 32'h0,         4'h3, 1,   1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, 4, 2, 4'h0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strobe = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sel_en", {sel, enable}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_addr", addr, 0);
        check("rst_strobe", strobe, 0);
        check("rst_rsp", {rsp_slverr, rsp_timeout, rsp_rdata}, 0);
        rst_n = 1'b1;
        #1 check("rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b1);

        // Response backpressure, then accept a new command in the ack cycle.
        b = '{1'b1, 32'h40, 32'h1122_3344, 4'h3, 0, 1'b0, 32'hEEEE_EEEE, 32'h0, 1'b0, 1'b0, 3, 1, 4'h3};
        run_vec(b, 1'b0);
        s_rdata = rsp_rdata; s_serr = rsp_slverr; s_to = rsp_timeout;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44; cmd_strobe = 4'hF;
        cpl_rdata = 32'hCAFE_0001; cpl_slverr = 1'b0; wait_cfg = 0;
        stable_err = 0;
        repeat (3) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== s_rdata || rsp_slverr !== s_serr ||
                rsp_timeout !== s_to || cmd_ready !== 1'b0 || sel !== 1'b0) stable_err++;
        end
        check("backpressure_hold", stable_err, 0);
        rsp_ready = 1'b1;
        #1 check("b2b_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        check("b2b_setup", {sel, enable, rsp_valid}, 3'b100);
        check("b2b_addr", addr, 32'h44);
        check("b2b_strobe", strobe, 0);
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            if (rsp_valid) done = 1;
        end
        check("b2b_rsp_seen", done, 1);
        check("b2b_rdata", rsp_rdata, 32'hCAFE_0001);
        ack_rsp();

        // Asynchronous reset while the completer is stalling.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50; wait_cfg = 100;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_enable", enable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bus", {sel, enable}, 0);
        check("async_rst_rsp", rsp_valid, 0);
        check("async_rst_addr", addr, 0);
        @(negedge clk);
        rst_n = 1'b1; wait_cfg = 0;
        #1 check("post_rst_cmd_ready", cmd_ready, 1);
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || sel) spurious++;
        end
        check("no_spurious_rsp", spurious, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB requester stage that sits directly upstream of the bridge's APB slave and drives its sel/enable/addr/write/wdata/strobe.
- Accepts single read or write commands on a valid/ready command port.
- Sequences each command through the APB SETUP and ACCESS phases, then returns rdata/slverr on a held response port.
- Has a ready-wait timeout so a stalled completer cannot hang the bridge.

Parameters:
- ADDR_WIDTH, 32: width of cmd_addr and addr.
- DATA_WIDTH, 32: width of the data buses. strobe width is DATA_WIDTH/8.
- TIMEOUT, 16: maximum ACCESS cycles to wait for ready. 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a clk edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strobe  in  DATA_WIDTH/8  byte lanes.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts.
- rsp_slverr  out  1  completer error or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- sel  out  1  APB select.
- enable  out  1  APB enable.
- addr  out  ADDR_WIDTH  APB address.
- write  out  1  APB direction.
- wdata  out  DATA_WIDTH  APB write data.
- strobe  out  DATA_WIDTH/8  APB write strobe.
- ready  in  1  completer ready.
- slverr  in  1  completer error, sampled only with ready.
- rdata  in  DATA_WIDTH  completer read data, sampled only with ready and !write.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All outputs are registered except cmd_ready.
- Reset values: state = IDLE; sel, enable, write, rsp_valid, rsp_slverr, rsp_timeout = 0; addr, wdata, strobe, rsp_rdata = 0.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at reset values. No response is generated for the aborted command.
- States: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = 1 only when (state == IDLE) or (state == RESP & rsp_ready).
- IDLE/RESP, on command accept:
  - Register addr, write and wdata from the command.
  - strobe = cmd_strobe for writes, forced to 0 for reads.
  - Next cycle: sel = 1, enable = 0, state SETUP.
- SETUP (exactly 1 cycle): next state ACCESS with enable = 1. The ready-wait counter clears to 0.
- ACCESS:
  - addr, write, wdata and strobe stay stable until completion.
  - ready = 1 at the edge: capture slverr into rsp_slverr. Capture rdata into rsp_rdata if read and !slverr, else 0. rsp_timeout = 0, rsp_valid = 1, sel = 0, enable = 0, state RESP.
  - ready = 0 and TIMEOUT != 0 and counter == TIMEOUT-1: abort. sel = 0, enable = 0, rsp_valid = 1, rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0, state RESP.
  - Otherwise: counter increments, stay in ACCESS.
- RESP:
  - Hold all rsp_* stable while rsp_valid & !rsp_ready.
  - rsp_ready = 1 with no new command: rsp_valid = 0, state IDLE.
  - rsp_ready = 1 with cmd_valid = 1 in the same cycle: the new command is accepted and goes to SETUP next cycle (rsp_valid = 0). Back-to-back spacing is therefore one idle APB cycle.
- Latency, command accept to rsp_valid, with zero wait states: 3 cycles (SETUP, ACCESS, then the RESP register). Each completer wait state adds 1 cycle.
- At most one outstanding command; no command buffering.
- Command and response fields are sampled only at their handshake edges. Changes at other times are ignored.
- The ready-wait counter is $clog2(TIMEOUT+1) bits wide and saturates. It is unused when TIMEOUT = 0.
- Address and data are passed through unchanged; no alignment checking in this block (range errors come back from the completer as slverr).

Test Plan:
- Write, zero wait states: cmd addr = 0x10, wdata = 0xA5A5_1234, strobe = 0xF; ready high on first ACCESS -> sel high 2 cycles, enable 1 cycle, strobe = 0xF; rsp_valid 3 cycles after accept with rsp_slverr = 0, rsp_rdata = 0.
- Read, 2 wait states: read addr = 0x20, cmd_strobe = 0xF, rdata = 0xDEAD_BEEF with ready after 2 low cycles -> strobe = 0 on the bus; enable high 3 cycles; rsp_rdata = 0xDEAD_BEEF; rsp_valid 5 cycles after accept.
- Slave error: read with slverr = 1 and ready = 1, rdata = 0x1234 -> rsp_slverr = 1, rsp_rdata = 0, rsp_timeout = 0.
- Timeout: TIMEOUT = 4, ready held 0 -> enable high exactly 4 cycles, then sel = 0; rsp_slverr = 1, rsp_timeout = 1.
- Response backpressure and back-to-back: rsp_ready = 0 for 3 cycles -> rsp_* stable and cmd_ready = 0; then rsp_ready = 1 with cmd_valid = 1 -> new SETUP on the next cycle.
- Reset mid-ACCESS: drop rst_n during wait states -> sel, enable and rsp_valid go 0 asynchronously; after release, cmd_ready = 1 and no spurious response.
